// File: rtl/fl_ckpt_ctrl_pkg.sv
// Shared sizing, FSM encoding and bus payloads for the free-list branch-checkpoint controller.
package fl_ckpt_ctrl_pkg;

  localparam int unsigned NUM_SUPER  = 2;
  localparam int unsigned NUM_CKPT   = 4;
  localparam int unsigned CKPT_TAG_W = $clog2(NUM_CKPT);
  localparam int unsigned CKPT_PTR_W = CKPT_TAG_W + 1;
  localparam int unsigned FL_IDX_W   = 5;

  typedef enum logic {IDLE, RECOVER} ckpt_state_e;

  typedef struct packed {
    logic                                  ckpt_avail;
    logic [NUM_SUPER-1:0][CKPT_TAG_W-1:0]  ckpt_tag;
  } DECODER_CKPT_OUT_t;

  typedef struct packed {
    logic recovering;
  } BR_CKPT_OUT_t;

  typedef struct packed {
    logic                rollback_en;
    logic [FL_IDX_W-1:0] FL_rollback_idx;
  } CKPT_FL_OUT_t;

  // Number of branches in a dispatch group, sized for pointer arithmetic.
  function automatic logic [CKPT_PTR_W-1:0] br_count(input logic [NUM_SUPER-1:0] v);
    br_count = '0;
    for (int i = 0; i < int'(NUM_SUPER); i++) br_count = br_count + CKPT_PTR_W'(v[i]);
  endfunction

endpackage

// File: rtl/fl_ckpt_younger_mask.sv
// Marks the resolving entry and every younger entry up to the tail, wrap-aware via head-relative offsets.
module ckpt_younger_mask
  import fl_ckpt_ctrl_pkg::*;
(
  input  logic [CKPT_PTR_W-1:0] head_i,
  input  logic [CKPT_PTR_W-1:0] tail_i,
  input  logic [CKPT_TAG_W-1:0] tag_i,
  output logic [NUM_CKPT-1:0]   mask_o
);

  logic [CKPT_PTR_W-1:0] count;
  logic [CKPT_TAG_W-1:0] off_t;
  logic [CKPT_TAG_W-1:0] off_j;

  always_comb begin
    count  = tail_i - head_i;
    off_t  = tag_i - head_i[CKPT_TAG_W-1:0];
    off_j  = '0;
    mask_o = '0;
    for (int j = 0; j < int'(NUM_CKPT); j++) begin
      off_j     = CKPT_TAG_W'(j) - head_i[CKPT_TAG_W-1:0];
      mask_o[j] = (off_j >= off_t) && (CKPT_PTR_W'(off_j) < count);
    end
  end

endmodule

// File: rtl/fl_ckpt_ctrl.sv
// Branch-checkpoint controller: snapshots FL tail per dispatched branch and
// drives a zero-cycle FL rollback on a mispredict.
module fl_ckpt_ctrl
  import fl_ckpt_ctrl_pkg::*;
(
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 dispatch_en_i,
  input  logic [NUM_SUPER-1:0]                 branch_valid_i,
  input  logic [NUM_SUPER-1:0][FL_IDX_W-1:0]   FL_idx_i,
  input  logic                                 resolve_valid_i,
  input  logic [CKPT_TAG_W-1:0]                resolve_tag_i,
  input  logic                                 resolve_mispredict_i,
  output logic                                 ckpt_avail_o,
  output logic [NUM_SUPER-1:0][CKPT_TAG_W-1:0] ckpt_tag_o,
  output logic                                 rollback_en_o,
  output logic [FL_IDX_W-1:0]                  FL_rollback_idx_o,
  output logic                                 recovering_o
);

  ckpt_state_e                          state_q, state_d;
  logic [CKPT_PTR_W-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CKPT_PTR_W-1:0]                count_c, free_c, n_br_c;
  logic [NUM_CKPT-1:0]                  valid_q, valid_d, kill_mask_c;
  logic [NUM_CKPT-1:0][FL_IDX_W-1:0]    idx_q, idx_d;
  logic [CKPT_TAG_W-1:0]                rel_tag_c;
  logic                                 mispredict_c, hit_c, alloc_c;
  DECODER_CKPT_OUT_t                    dec_out_c;
  CKPT_FL_OUT_t                         fl_out_c;
  BR_CKPT_OUT_t                         br_out;

  ckpt_younger_mask u_mask (
    .head_i (head_q),
    .tail_i (tail_q),
    .tag_i  (resolve_tag_i),
    .mask_o (kill_mask_c)
  );

  // Availability, tag assignment and rollback decode.
  always_comb begin
    count_c   = tail_q - head_q;
    free_c    = CKPT_PTR_W'(NUM_CKPT) - count_c;
    n_br_c    = br_count(branch_valid_i);
    dec_out_c.ckpt_avail  = (state_q == IDLE) && (free_c >= n_br_c);
    dec_out_c.ckpt_tag[0] = tail_q[CKPT_TAG_W-1:0];
    dec_out_c.ckpt_tag[1] = (branch_valid_i == 2'b10) ? tail_q[CKPT_TAG_W-1:0]
                                                       : tail_q[CKPT_TAG_W-1:0] + CKPT_TAG_W'(1);
    mispredict_c = resolve_valid_i && resolve_mispredict_i;
    hit_c        = mispredict_c && valid_q[resolve_tag_i] && !reset;
    fl_out_c.rollback_en     = hit_c;
    fl_out_c.FL_rollback_idx = idx_q[resolve_tag_i];
    alloc_c   = dispatch_en_i && dec_out_c.ckpt_avail && !mispredict_c;
    rel_tag_c = resolve_tag_i - head_q[CKPT_TAG_W-1:0];
  end

  // Next-state: resolve clear, allocation, rollback truncation, then head reclaim.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    tail_d  = tail_q;
    head_d  = head_q;
    state_d = IDLE;
    if (resolve_valid_i && !resolve_mispredict_i) valid_d[resolve_tag_i] = 1'b0;
    if (alloc_c) begin
      for (int i = 0; i < int'(NUM_SUPER); i++) begin
        if (branch_valid_i[i]) begin
          valid_d[dec_out_c.ckpt_tag[i]] = 1'b1;
          idx_d[dec_out_c.ckpt_tag[i]]   = FL_idx_i[i];
        end
      end
      tail_d = tail_q + n_br_c;
    end
    if (hit_c) begin
      valid_d = valid_d & ~kill_mask_c;
      tail_d  = head_q + CKPT_PTR_W'(rel_tag_c) + CKPT_PTR_W'(1);
      state_d = RECOVER;
    end
    // Walking head_d sequentially makes the two-step reclaim stop at the first valid entry.
    for (int k = 0; k < 2; k++) begin
      if ((head_d != tail_d) && !valid_d[head_d[CKPT_TAG_W-1:0]]) head_d = head_d + CKPT_PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign br_out.recovering = (state_q == RECOVER);

  assign ckpt_avail_o      = dec_out_c.ckpt_avail;
  assign ckpt_tag_o        = dec_out_c.ckpt_tag;
  assign rollback_en_o     = fl_out_c.rollback_en;
  assign FL_rollback_idx_o = fl_out_c.FL_rollback_idx;
  assign recovering_o      = br_out.recovering;

endmodule

// File: tb/tb_fl_ckpt_ctrl.sv
// Scoreboard bench for fl_ckpt_ctrl: expected tags and rollback indices queued at drive time.
module tb_fl_ckpt_ctrl;
  import fl_ckpt_ctrl_pkg::*;

  typedef logic [NUM_SUPER-1:0][CKPT_TAG_W-1:0] tags_t;

  logic                               clock = 1'b0;
  logic                               reset;
  logic                               dispatch_en;
  logic [NUM_SUPER-1:0]               branch_valid;
  logic [NUM_SUPER-1:0][FL_IDX_W-1:0] FL_idx;
  logic                               resolve_valid;
  logic [CKPT_TAG_W-1:0]              resolve_tag;
  logic                               resolve_mispredict;
  logic                               ckpt_avail;
  tags_t                              ckpt_tag;
  logic                               rollback_en;
  logic [FL_IDX_W-1:0]                FL_rollback_idx;
  logic                               recovering;

  int n_cmp = 0;
  int n_err = 0;
  tags_t               tag_exp_q[$];
  logic [FL_IDX_W-1:0] rb_exp_q[$];
  tags_t               exp_tag;
  logic [FL_IDX_W-1:0] exp_rb;

  fl_ckpt_ctrl dut (
    .clock(clock), .reset(reset), .dispatch_en_i(dispatch_en), .branch_valid_i(branch_valid),
    .FL_idx_i(FL_idx), .resolve_valid_i(resolve_valid), .resolve_tag_i(resolve_tag),
    .resolve_mispredict_i(resolve_mispredict), .ckpt_avail_o(ckpt_avail), .ckpt_tag_o(ckpt_tag),
    .rollback_en_o(rollback_en), .FL_rollback_idx_o(FL_rollback_idx), .recovering_o(recovering)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in;
    dispatch_en = 1'b0; branch_valid = '0; FL_idx = '0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_mispredict = 1'b0;
  endtask

  task automatic drive_dispatch(input logic [1:0] bv, input logic [4:0] fl1, input logic [4:0] fl0,
                                input logic [1:0] t1, input logic [1:0] t0);
    dispatch_en = 1'b1; branch_valid = bv; FL_idx[1] = fl1; FL_idx[0] = fl0;
    tag_exp_q.push_back({t1, t0});
  endtask

  task automatic drive_mispredict(input logic [1:0] t, input bit hit, input logic [4:0] rb);
    resolve_valid = 1'b1; resolve_mispredict = 1'b1; resolve_tag = t;
    if (hit) rb_exp_q.push_back(rb);
  endtask

  task automatic test_reset;
    idle_in; reset = 1'b1; resolve_valid = 1'b1; resolve_mispredict = 1'b1;
    tick; tick;
    reset = 1'b0; idle_in; #1;
    n_cmp++; if (ckpt_avail !== 1'b1) begin n_err++; $display("FAIL reset_avail got %b exp 1", ckpt_avail); end
    n_cmp++; if (rollback_en !== 1'b0) begin n_err++; $display("FAIL reset_rollback got %b exp 0", rollback_en); end
    n_cmp++; if (FL_rollback_idx !== 5'd0) begin n_err++; $display("FAIL reset_rb_idx got %0d exp 0", FL_rollback_idx); end
    n_cmp++; if (ckpt_tag !== tags_t'({2'd1, 2'd0})) begin n_err++; $display("FAIL reset_tag got %h exp 4", ckpt_tag); end
    n_cmp++; if (recovering !== 1'b0) begin n_err++; $display("FAIL reset_recovering got %b exp 0", recovering); end
    branch_valid = 2'b11; #1;
    n_cmp++; if (ckpt_avail !== 1'b1) begin n_err++; $display("FAIL reset_avail2 got %b exp 1", ckpt_avail); end
    idle_in;
  endtask

  task automatic test_dispatch_pair;
    drive_dispatch(2'b11, 5'd7, 5'd6, 2'd1, 2'd0); #1;
    exp_tag = tag_exp_q.pop_front();
    n_cmp++; if (ckpt_tag !== exp_tag) begin n_err++; $display("FAIL pair_tag got %h exp %h", ckpt_tag, exp_tag); end
    n_cmp++; if (ckpt_avail !== 1'b1) begin n_err++; $display("FAIL pair_avail got %b exp 1", ckpt_avail); end
    tick; idle_in; #1;
    n_cmp++; if (ckpt_tag !== tags_t'({2'd3, 2'd2})) begin n_err++; $display("FAIL pair_next_tag got %h exp e", ckpt_tag); end
  endtask

  task automatic test_fill_full;
    drive_dispatch(2'b10, 5'd8, 5'd0, 2'd2, 2'd2); #1;
    exp_tag = tag_exp_q.pop_front();
    n_cmp++; if (ckpt_tag !== exp_tag) begin n_err++; $display("FAIL slot1_tag got %h exp %h", ckpt_tag, exp_tag); end
    tick; idle_in;
    drive_dispatch(2'b01, 5'd0, 5'd9, 2'd0, 2'd3); #1;
    exp_tag = tag_exp_q.pop_front();
    n_cmp++; if (ckpt_tag !== exp_tag) begin n_err++; $display("FAIL slot0_tag got %h exp %h", ckpt_tag, exp_tag); end
    tick; idle_in;
    branch_valid = 2'b01; #1;
    n_cmp++; if (ckpt_avail !== 1'b0) begin n_err++; $display("FAIL full_one_br got %b exp 0", ckpt_avail); end
    branch_valid = 2'b11; #1;
    n_cmp++; if (ckpt_avail !== 1'b0) begin n_err++; $display("FAIL full_two_br got %b exp 0", ckpt_avail); end
    branch_valid = 2'b00; dispatch_en = 1'b1; #1;
    n_cmp++; if (ckpt_avail !== 1'b1) begin n_err++; $display("FAIL full_no_br got %b exp 1", ckpt_avail); end
    tick; idle_in; #1;
    n_cmp++; if (ckpt_tag !== tags_t'({2'd1, 2'd0})) begin n_err++; $display("FAIL full_tag got %h exp 4", ckpt_tag); end
  endtask

  task automatic test_correct_resolve;
    resolve_valid = 1'b1; resolve_tag = 2'd1; tick; idle_in;
    branch_valid = 2'b01; #1;
    n_cmp++; if (ckpt_avail !== 1'b0) begin n_err++; $display("FAIL res1_head_held got %b exp 0", ckpt_avail); end
    idle_in; resolve_valid = 1'b1; resolve_tag = 2'd0; tick; idle_in;
    branch_valid = 2'b11; #1;
    n_cmp++; if (ckpt_avail !== 1'b1) begin n_err++; $display("FAIL res0_head_jump got %b exp 1", ckpt_avail); end
    drive_dispatch(2'b11, 5'd11, 5'd10, 2'd1, 2'd0); #1;
    exp_tag = tag_exp_q.pop_front();
    n_cmp++; if (ckpt_tag !== exp_tag) begin n_err++; $display("FAIL refill_tag got %h exp %h", ckpt_tag, exp_tag); end
    tick; idle_in; branch_valid = 2'b01; #1;
    n_cmp++; if (ckpt_avail !== 1'b0) begin n_err++; $display("FAIL refill_full got %b exp 0", ckpt_avail); end
    idle_in;
  endtask

  task automatic test_mispredict;
    drive_mispredict(2'd3, 1'b1, 5'd9); #1;
    exp_rb = rb_exp_q.pop_front();
    n_cmp++; if (rollback_en !== 1'b1) begin n_err++; $display("FAIL mp_rollback got %b exp 1", rollback_en); end
    n_cmp++; if (FL_rollback_idx !== exp_rb) begin n_err++; $display("FAIL mp_rb_idx got %0d exp %0d", FL_rollback_idx, exp_rb); end
    tick; idle_in; #1;
    n_cmp++; if (recovering !== 1'b1) begin n_err++; $display("FAIL mp_recovering got %b exp 1", recovering); end
    n_cmp++; if (ckpt_avail !== 1'b0) begin n_err++; $display("FAIL mp_avail got %b exp 0", ckpt_avail); end
    n_cmp++; if (ckpt_tag !== tags_t'({2'd1, 2'd0})) begin n_err++; $display("FAIL mp_tail got %h exp 4", ckpt_tag); end
    tick; #1;
    n_cmp++; if (recovering !== 1'b0) begin n_err++; $display("FAIL mp_recover_end got %b exp 0", recovering); end
    branch_valid = 2'b11; #1;
    n_cmp++; if (ckpt_avail !== 1'b1) begin n_err++; $display("FAIL mp_freed got %b exp 1", ckpt_avail); end
    idle_in;
    drive_mispredict(2'd0, 1'b0, 5'd0); #1;
    n_cmp++; if (rollback_en !== 1'b0) begin n_err++; $display("FAIL mp_invalid got %b exp 0", rollback_en); end
    tick; idle_in; #1;
    n_cmp++; if (recovering !== 1'b0) begin n_err++; $display("FAIL mp_invalid_state got %b exp 0", recovering); end
    n_cmp++; if (ckpt_tag !== tags_t'({2'd1, 2'd0})) begin n_err++; $display("FAIL mp_invalid_tail got %h exp 4", ckpt_tag); end
  endtask

  task automatic test_mispredict_with_dispatch;
    drive_mispredict(2'd2, 1'b1, 5'd8);
    dispatch_en = 1'b1; branch_valid = 2'b11; FL_idx[1] = 5'd13; FL_idx[0] = 5'd12; #1;
    exp_rb = rb_exp_q.pop_front();
    n_cmp++; if (rollback_en !== 1'b1) begin n_err++; $display("FAIL mpd_rollback got %b exp 1", rollback_en); end
    n_cmp++; if (FL_rollback_idx !== exp_rb) begin n_err++; $display("FAIL mpd_rb_idx got %0d exp %0d", FL_rollback_idx, exp_rb); end
    tick; idle_in; #1;
    n_cmp++; if (ckpt_tag !== tags_t'({2'd0, 2'd3})) begin n_err++; $display("FAIL mpd_tail got %h exp 3", ckpt_tag); end
    n_cmp++; if (recovering !== 1'b1) begin n_err++; $display("FAIL mpd_recovering got %b exp 1", recovering); end
    tick;
  endtask

  task automatic test_wrap;
    logic [1:0] t;
    for (int k = 0; k < 7; k++) begin
      t = 2'(3 + k);
      drive_dispatch(2'b01, 5'd0, 5'(20 + k), t + 2'd1, t); #1;
      exp_tag = tag_exp_q.pop_front();
      n_cmp++; if (ckpt_tag !== exp_tag) begin n_err++; $display("FAIL wrap_tag[%0d] got %h exp %h", k, ckpt_tag, exp_tag); end
      tick; idle_in;
      resolve_valid = 1'b1; resolve_tag = t; tick; idle_in;
    end
    drive_dispatch(2'b11, 5'd31, 5'd30, 2'd3, 2'd2); #1;
    exp_tag = tag_exp_q.pop_front();
    n_cmp++; if (ckpt_tag !== exp_tag) begin n_err++; $display("FAIL wrap_pair0 got %h exp %h", ckpt_tag, exp_tag); end
    tick; idle_in;
    drive_dispatch(2'b11, 5'd1, 5'd2, 2'd1, 2'd0); #1;
    exp_tag = tag_exp_q.pop_front();
    n_cmp++; if (ckpt_tag !== exp_tag) begin n_err++; $display("FAIL wrap_pair1 got %h exp %h", ckpt_tag, exp_tag); end
    tick; idle_in; branch_valid = 2'b01; #1;
    n_cmp++; if (ckpt_avail !== 1'b0) begin n_err++; $display("FAIL wrap_full got %b exp 0", ckpt_avail); end
    idle_in;
    drive_mispredict(2'd0, 1'b1, 5'd2); #1;
    exp_rb = rb_exp_q.pop_front();
    n_cmp++; if (FL_rollback_idx !== exp_rb || rollback_en !== 1'b1) begin n_err++; $display("FAIL wrap_mp got en=%b idx=%0d exp en=1 idx=%0d", rollback_en, FL_rollback_idx, exp_rb); end
    tick; idle_in; #1;
    n_cmp++; if (ckpt_tag !== tags_t'({2'd2, 2'd1})) begin n_err++; $display("FAIL wrap_tail got %h exp 9", ckpt_tag); end
    tick; branch_valid = 2'b01; #1;
    n_cmp++; if (ckpt_avail !== 1'b1) begin n_err++; $display("FAIL wrap_free1 got %b exp 1", ckpt_avail); end
    branch_valid = 2'b11; #1;
    n_cmp++; if (ckpt_avail !== 1'b0) begin n_err++; $display("FAIL wrap_free_lt2 got %b exp 0", ckpt_avail); end
    idle_in;
    drive_mispredict(2'd1, 1'b0, 5'd0); #1;
    n_cmp++; if (rollback_en !== 1'b0) begin n_err++; $display("FAIL wrap_cleared1 got %b exp 0", rollback_en); end
    tick; idle_in;
    drive_mispredict(2'd3, 1'b1, 5'd31); #1;
    exp_rb = rb_exp_q.pop_front();
    n_cmp++; if (FL_rollback_idx !== exp_rb || rollback_en !== 1'b1) begin n_err++; $display("FAIL wrap_kept3 got en=%b idx=%0d exp en=1 idx=%0d", rollback_en, FL_rollback_idx, exp_rb); end
    tick; idle_in; #1;
    n_cmp++; if (ckpt_tag !== tags_t'({2'd1, 2'd0})) begin n_err++; $display("FAIL wrap_tail2 got %h exp 4", ckpt_tag); end
  endtask

  task automatic test_reset_priority;
    reset = 1'b1;
    drive_mispredict(2'd2, 1'b0, 5'd0);
    dispatch_en = 1'b1; branch_valid = 2'b11;
    tick; reset = 1'b0; idle_in; #1;
    n_cmp++; if (recovering !== 1'b0) begin n_err++; $display("FAIL rstp_recovering got %b exp 0", recovering); end
    n_cmp++; if (ckpt_avail !== 1'b1) begin n_err++; $display("FAIL rstp_avail got %b exp 1", ckpt_avail); end
    n_cmp++; if (FL_rollback_idx !== 5'd0) begin n_err++; $display("FAIL rstp_rb_idx got %0d exp 0", FL_rollback_idx); end
    drive_dispatch(2'b11, 5'd3, 5'd4, 2'd1, 2'd0); #1;
    exp_tag = tag_exp_q.pop_front();
    n_cmp++; if (ckpt_tag !== exp_tag) begin n_err++; $display("FAIL rstp_tag got %h exp %h", ckpt_tag, exp_tag); end
    tick; idle_in;
  endtask

  initial begin
    idle_in;
    reset = 1'b1;
    test_reset;
    test_dispatch_pair;
    test_fill_full;
    test_correct_resolve;
    test_mispredict;
    test_mispredict_with_dispatch;
    test_wrap;
    test_reset_priority;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fl_ckpt_ctrl.md
# fl_ckpt_ctrl

Branch-checkpoint controller for the free list. At dispatch it captures the free-list tail index reached after each branch's own allocation into a small circular checkpoint buffer and hands a checkpoint tag to the branch. When a branch resolves mispredicted, it drives `rollback_en`/`FL_rollback_idx` into the free list and discards all younger checkpoints. It sits between decode/dispatch, the branch-resolution path and FL.

## Interface
- `NUM_SUPER`, 2: dispatch width; the block is fixed at 2.
- `NUM_CKPT`, 4: checkpoint entries; must be a power of 2.
- `FL_IDX_W`, 5: width of a free-list index, `$clog2(NUM_FL)`.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `dispatch_en`  in  1  dispatch group accepted this cycle.
- `branch_valid`  in  NUM_SUPER  slot i is a branch.
- `FL_idx`  in  NUM_SUPER x FL_IDX_W  FL tail after slot i's allocation; taken from FL's `FL_idx`.
- `resolve_valid`  in  1  a branch resolves this cycle.
- `resolve_tag`  in  $clog2(NUM_CKPT)  checkpoint tag of the resolving branch.
- `resolve_mispredict`  in  1  the resolving branch was mispredicted.
- `ckpt_avail`  out  1  enough free entries for this cycle's `branch_valid` and state is IDLE; dispatch stalls when 0.
- `ckpt_tag`  out  NUM_SUPER x $clog2(NUM_CKPT)  tag assigned to slot i; valid only when that slot is a branch.
- `rollback_en`  out  1  to FL; combinational in the mispredict cycle.
- `FL_rollback_idx`  out  FL_IDX_W  stored index of `resolve_tag`.
- `recovering`  out  1  high in the cycle after a mispredict.

## Operation
- State: `head_ptr`, `tail_ptr` (each $clog2(NUM_CKPT)+1 bits, with wrap bit), `valid[NUM_CKPT]`, `idx[NUM_CKPT]`, and an FSM {IDLE, RECOVER}.
- Occupancy: `count = tail_ptr - head_ptr`, modulo 2^(W+1). Free entries = `NUM_CKPT - count`.
- `ckpt_avail` = (state==IDLE) && (free ≥ popcount(branch_valid)).
- Tags: the first branch slot gets `tail_ptr[W-1:0]`. If both slots are branches, slot 1 gets +1. If only slot 1 is a branch, it gets `tail_ptr`.
- Allocate when `dispatch_en && ckpt_avail && !(resolve_valid && resolve_mispredict)`.
  - Write `idx` with the matching `FL_idx[i]` and set `valid`.
  - `tail_ptr` advances by popcount(branch_valid).
- Correct resolve (`resolve_valid && !resolve_mispredict`): clear `valid[resolve_tag]`. An already-invalid tag is ignored.
- Reclaim: `head_ptr` advances past up to 2 consecutive invalid entries per cycle, never passing `tail_ptr`.
- Mispredict on a valid tag t:
  - `rollback_en=1`, `FL_rollback_idx=idx[t]`.
  - Clear `valid[t]` and all entries from t+1 to tail.
  - Next `tail_ptr` = head-relative position of t+1.
  - Same-cycle allocations are dropped.
  - FSM goes to RECOVER.
- Mispredict on an invalid tag: `rollback_en=0`, no state change.
- RECOVER: lasts exactly 1 cycle. `ckpt_avail=0`, `recovering=1`. Resolves are still processed, then the FSM returns to IDLE.
- Reset: pointers 0, `valid` all 0, `idx` all 0, state IDLE.
  - Outputs after reset: `ckpt_avail=1`, `rollback_en=0`, `FL_rollback_idx=0`, `ckpt_tag={1,0}`, `recovering=0`.
  - Reset has priority over every event, including a mispredict in the same cycle.

## Timing
- Allocation: written at the clock edge. The tag is combinational in the dispatch cycle.
- Rollback: zero-cycle, combinational from `resolve_*`. FL applies it at the same edge.
- Freed entries are usable for allocation 1 cycle after the resolve edge.
- Full: count==NUM_CKPT forces `ckpt_avail=0` whenever any `branch_valid` is set. A non-branch group is still accepted.
- Wrap: pointer arithmetic is modulo 2^(W+1); the full vs empty distinction uses the wrap bit.

## Structure
- Shared package holds `NUM_CKPT`, `CKPT_TAG_W`, and the structs `DECODER_CKPT_OUT_t`, `BR_CKPT_OUT_t`, `CKPT_FL_OUT_t`, which carry `rollback_en` and `FL_rollback_idx`.
- One sub-module, `ckpt_younger_mask`: given head, tail and t, it produces the NUM_CKPT-bit invalidate mask, wrap-aware.

## Test plan
- After reset, dispatch 2 branches with `FL_idx={7,6}` -> tags {1,0}, idx[0]=6, idx[1]=7, count=2.
- Fill 4 entries, then present 1 branch -> `ckpt_avail=0`. Present a group with no branch -> `ckpt_avail=1`.
- Entries 0..3 valid; mispredict tag 1 with idx[1]=9 -> `rollback_en=1` and `FL_rollback_idx=9` in the same cycle. Next cycle `tail_ptr`=2, `recovering=1`, `ckpt_avail=0`.
- Correct-resolve tag 1, then tag 0 -> head stays at 0 after the first resolve and jumps to 2 after the second.
- Mispredict together with a dispatch of 2 branches -> no allocation, `tail_ptr` only from the rollback.
- Wrap: allocate and free 6 times, mispredict the entry at physical index 1 after wrap -> mask clears only the younger wrapped entries.
